rv32i_instr_encoder_loader: RTL and testbench
=============================================

# rv32i_instr_encoder_loader

Sequential RV32I instruction encoder and instruction-memory loader. It is the inverse of the opcode type decoder: it accepts a one-hot instruction class plus register, funct and immediate fields over a valid/ready stream, packs them into legal 32-bit RV32I words, and writes them to consecutive instruction-memory words. It sits between the test/boot program source and the instruction memory of the single-cycle core. Throughput is one word per cycle.

## Interface
- ADDR_WIDTH, default 8: instruction-memory word-address width. Depth is 2**ADDR_WIDTH words.

- clk  in  1  clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a load session at base_addr
- base_addr  in  ADDR_WIDTH  first word address, sampled on start
- stop  in  1  pulse; ends the session after any pending write
- in_valid  in  1  field beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- itype  in  9  one-hot class {lui,auipc,jal,jalr,branch,store,load,i_type,r_type}, bit 8..0
- rd, rs1, rs2  in  5 each  register fields
- funct3  in  3; funct7  in  7
- imm  in  32  immediate, already sign-correct, byte offsets for branch/jal
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  32  encoded instruction
- busy  out  1  session active (RUN or DRAIN)
- done  out  1  one-cycle pulse at session end
- full  out  1  sticky, last memory word written; cleared by start
- err  out  1  sticky, non-one-hot itype seen; cleared by start
- count  out  ADDR_WIDTH+1  words written this session

## Operation
- FSM: IDLE, RUN, DRAIN.
- IDLE: in_ready=0. On start, addr<=base_addr, count/err/full<=0, go to RUN.
- RUN: in_ready=1. An accepted beat with a legal itype loads the one-entry write register. Next cycle: mem_we=1, mem_addr=addr, addr<=addr+1, count<=count+1.
- An illegal itype (zero bits or multiple bits set) is consumed. It is not written, it sets err, and addr/count are unchanged.
- RUN -> DRAIN on stop. A beat accepted in the same cycle as stop is still written.
- RUN -> DRAIN when the accepted beat targets address 2**ADDR_WIDTH-1. full is set when that word is written. The address does not wrap to 0 for further writes.
- DRAIN: in_ready=0. Completes any pending write, pulses done, goes to IDLE.
- start is ignored outside IDLE.
- Encoding, with opcodes from the shared package:
  - R: funct7|rs2|rs1|funct3|rd|0110011
  - I-ALU: imm[11:0]|rs1|funct3|rd|0010011. For funct3 001/101, bits[31:25]=funct7 and bits[24:20]=imm[4:0].
  - Load: I layout with 0000011.
  - JALR: I layout, funct3 forced to 000, opcode 1100111.
  - Store: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011.
  - Branch: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
  - LUI/AUIPC: imm[31:12]|rd|0110111 / 0010111.
  - Unused imm bits, including imm[0] for branch/jal, are ignored.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, full=0, err=0, count=0, state IDLE.
- Latency: beat accepted at cycle N appears on mem_we/mem_addr/mem_wdata at cycle N+1, all registered.
- in_ready rises the cycle after start. busy is 1 in the same cycles.
- done pulses exactly one cycle, on the DRAIN cycle. busy is 0 from the next cycle.
- Reset mid-session: the pending write is discarded and no mem_we follows. All outputs return to reset values on the next edge.
- start and stop asserted together in IDLE: start wins. stop is only observed in RUN.

## Structure
- Package rv32i_pkg holds the nine opcode localparams, the itype bit-index constants, and the FSM state enum. The same constants serve the type decoder.
- Sub-module rv32i_field_packer is the combinational packer: itype/fields in, 32-bit word plus legal flag out. The top module holds the FSM, address counter and write register.

## Test plan
- start with base_addr=0x10, one beat r_type rd=1 rs1=2 rs2=3 f3=0 f7=0x20 -> next cycle mem_we=1, addr=0x10, wdata=0x403100B3; count=1.
- Back-to-back branch imm=-4 rs1=1 rs2=0 f3=001, then jal rd=1 imm=0x800 -> words 0xFE009EE3 and 0x001000EF at consecutive addresses, one per cycle.
- itype=9'b000000011 mid-stream -> no write, err=1, next legal beat goes to the unconsumed address.
- ADDR_WIDTH=2, base_addr=2, three beats -> writes at 2 and 3, full=1, done pulses, third beat never accepted.
- stop coincident with accepted i_type slli rd=5 rs1=5 imm=3 -> wdata=0x00329293 written, then done, then IDLE.
- rst asserted the cycle after a beat is accepted -> no mem_we, all outputs at reset values.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I opcodes, one-hot instruction class bit positions and loader FSM states.
// Used by the field packer and the opcode type decoder.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int unsigned IT_LUI    = 8;
  localparam int unsigned IT_AUIPC  = 7;
  localparam int unsigned IT_JAL    = 6;
  localparam int unsigned IT_JALR   = 5;
  localparam int unsigned IT_BRANCH = 4;
  localparam int unsigned IT_STORE  = 3;
  localparam int unsigned IT_LOAD   = 2;
  localparam int unsigned IT_ITYPE  = 1;
  localparam int unsigned IT_RTYPE  = 0;

  localparam int unsigned ITYPE_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/rv32i_field_packer.sv
// Combinational RV32I packer: one-hot class plus fields in, 32-bit word and legal flag out.
// Zero latency; no flow control of its own.
module rv32i_field_packer
  import rv32i_pkg::*;
(
  input  logic [ITYPE_W-1:0] itype,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [31:0]        imm,
  output logic [31:0]        word,
  output logic               legal
);

  logic shift_imm;

  always_comb begin
    word      = '0;
    // exactly one class bit: non-zero and clearing the lowest set bit leaves nothing
    legal     = (itype != '0) && ((itype & (itype - 9'd1)) == '0);
    shift_imm = (funct3 == 3'b001) || (funct3 == 3'b101);
    if (legal) begin
      if (itype[IT_RTYPE]) begin
        word = {funct7, rs2, rs1, funct3, rd, OPC_OP};
      end else if (itype[IT_ITYPE]) begin
        if (shift_imm) begin
          word = {funct7, imm[4:0], rs1, funct3, rd, OPC_OP_IMM};
        end else begin
          word = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
        end
      end else if (itype[IT_LOAD]) begin
        word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      end else if (itype[IT_JALR]) begin
        word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      end else if (itype[IT_STORE]) begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      end else if (itype[IT_BRANCH]) begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
      end else if (itype[IT_JAL]) begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      end else if (itype[IT_AUIPC]) begin
        word = {imm[31:12], rd, OPC_AUIPC};
      end else begin
        word = {imm[31:12], rd, OPC_LUI};
      end
    end
  end

endmodule

// File: rtl/rv32i_instr_encoder_loader.sv
// Encodes RV32I field beats and writes them to consecutive instruction-memory words.
// One-cycle registered write latency; in_ready is high only in RUN, one beat per cycle.
module rv32i_instr_encoder_loader
  import rv32i_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  stop,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ITYPE_W-1:0]    itype,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  full,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   count
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  err_q, err_d;
  logic                  full_q, full_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic [31:0] packed_word;
  logic        packed_legal;
  logic        accept;
  logic        last_addr;

  rv32i_field_packer u_packer (
    .itype  (itype),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .funct7 (funct7),
    .imm    (imm),
    .word   (packed_word),
    .legal  (packed_legal)
  );

  assign accept    = (state_q == ST_RUN) && in_valid;
  assign last_addr = &addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      full_q  <= full_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if ((accept && packed_legal && last_addr) || stop) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Write register, address counter and sticky flags.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    full_d  = full_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if ((state_q == ST_IDLE) && start) begin
      addr_d  = base_addr;
      count_d = '0;
      err_d   = 1'b0;
      full_d  = 1'b0;
    end else if (accept) begin
      if (packed_legal) begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = packed_word;
        addr_d  = addr_q + 1'b1;
        count_d = count_q + 1'b1;
        if (last_addr) full_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = (state_q == ST_RUN);
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DRAIN);
  end

  // A write still in the register when reset arrives never reaches memory.
  assign mem_we    = we_q & ~rst;
  assign mem_addr  = waddr_q;
  assign mem_wdata = wdata_q;
  assign full      = full_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_rv32i_instr_encoder_loader.sv
// Scoreboard bench for the RV32I encoder/loader: hand-encoded expected words queued per beat.
module tb_rv32i_instr_encoder_loader;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stop, in_valid, start2, in_valid2;
  logic [7:0]  base_addr;
  logic [1:0]  base_addr2;
  logic [8:0]  itype;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;

  logic        in_ready, mem_we, busy, done, full, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;

  logic        in_ready2, mem_we2, busy2, done2, full2, err2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  count2;

  rv32i_instr_encoder_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .itype(itype), .rd(rd), .rs1(rs1),
    .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .full(full), .err(err), .count(count)
  );

  rv32i_instr_encoder_loader #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .base_addr(base_addr2), .stop(stop),
    .in_valid(in_valid2), .in_ready(in_ready2), .itype(itype), .rd(rd), .rs1(rs1),
    .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .busy(busy2), .done(done2),
    .full(full2), .err(err2), .count(count2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  logic [63:0] q1[$];
  logic [63:0] q2[$];

  always @(negedge clk) begin
    logic [63:0] e;
    if (mem_we) begin
      if (q1.size() == 0) begin
        chk("wr1_spurious", 32'(mem_we), 32'd0);
      end else begin
        e = q1.pop_front();
        chk("wr1_addr", 32'(mem_addr), e[63:32]);
        chk("wr1_data", mem_wdata, e[31:0]);
      end
    end
    if (mem_we2) begin
      if (q2.size() == 0) begin
        chk("wr2_spurious", 32'(mem_we2), 32'd0);
      end else begin
        e = q2.pop_front();
        chk("wr2_addr", 32'(mem_addr2), e[63:32]);
        chk("wr2_data", mem_wdata2, e[31:0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat (optionally with stop) until accepted, bounded at 20 cycles.
  task automatic send(input int sel, input logic [8:0] it, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im, input logic with_stop);
    logic acc;
    acc    = 1'b0;
    itype  = it; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    stop   = with_stop;
    if (sel == 1) in_valid = 1'b1;
    else          in_valid2 = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = (sel == 1) ? in_ready : in_ready2;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    stop      = 1'b0;
    chk("accept", 32'(acc), 32'd1);
  endtask

  localparam logic [8:0] T_R  = 9'b000000001;
  localparam logic [8:0] T_I  = 9'b000000010;
  localparam logic [8:0] T_LD = 9'b000000100;
  localparam logic [8:0] T_ST = 9'b000001000;
  localparam logic [8:0] T_BR = 9'b000010000;
  localparam logic [8:0] T_JR = 9'b000100000;
  localparam logic [8:0] T_J  = 9'b001000000;
  localparam logic [8:0] T_AU = 9'b010000000;
  localparam logic [8:0] T_LU = 9'b100000000;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; start2 = 1'b0; in_valid2 = 1'b0;
    base_addr = '0; base_addr2 = '0; itype = '0; rd = '0; rs1 = '0; rs2 = '0;
    funct3 = '0; funct7 = '0; imm = '0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_busy2", 32'(busy2), 0);

    // Session 1: start together with stop in IDLE, start must win.
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1; base_addr = 8'h10;
    tick(1);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("s1_in_ready", 32'(in_ready), 1);
    chk("s1_busy", 32'(busy), 1);
    chk("s1_count0", 32'(count), 0);
    @(posedge clk); #1;
    q1.push_back({32'h10, 32'h403100B3}); send(1, T_R, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0, 1'b0);
    q1.push_back({32'h11, 32'hFE009EE3}); send(1, T_BR, 5'd0, 5'd1, 5'd0, 3'd1, 7'h00, -32'sd4, 1'b0);
    q1.push_back({32'h12, 32'h001000EF}); send(1, T_J, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h800, 1'b0);
    send(1, 9'b000000011, 5'd7, 5'd7, 5'd7, 3'd0, 7'h00, 32'd0, 1'b0);
    q1.push_back({32'h13, 32'h12345537}); send(1, T_LU, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345ABC, 1'b0);
    q1.push_back({32'h14, 32'hABCDE197}); send(1, T_AU, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'hABCDE000, 1'b0);
    q1.push_back({32'h15, 32'hFF812303}); send(1, T_LD, 5'd6, 5'd2, 5'd0, 3'd2, 7'h00, -32'sd8, 1'b0);
    q1.push_back({32'h16, 32'h00712623}); send(1, T_ST, 5'd0, 5'd2, 5'd7, 3'd2, 7'h00, 32'd12, 1'b0);
    q1.push_back({32'h17, 32'h010280E7}); send(1, T_JR, 5'd1, 5'd5, 5'd0, 3'd3, 7'h00, 32'd16, 1'b0);
    q1.push_back({32'h18, 32'hFFF00093}); send(1, T_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 1'b0);
    q1.push_back({32'h19, 32'h40315113}); send(1, T_I, 5'd2, 5'd2, 5'd0, 3'd5, 7'h20, 32'd3, 1'b0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    @(negedge clk);
    chk("s1_done", 32'(done), 1);
    chk("s1_drain_busy", 32'(busy), 1);
    chk("s1_drain_rdy", 32'(in_ready), 0);
    chk("s1_err", 32'(err), 1);
    chk("s1_count", 32'(count), 10);
    @(negedge clk);
    chk("s1_done_gone", 32'(done), 0);
    chk("s1_idle_busy", 32'(busy), 0);
    chk("s1_err_sticky", 32'(err), 1);

    // Session 2: stop coincident with an accepted slli.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h40;
    tick(1);
    start = 1'b0;
    @(negedge clk);
    chk("s2_err_clr", 32'(err), 0);
    chk("s2_count0", 32'(count), 0);
    @(posedge clk); #1;
    q1.push_back({32'h40, 32'h00329293}); send(1, T_I, 5'd5, 5'd5, 5'd0, 3'd1, 7'h00, 32'd3, 1'b1);
    @(negedge clk);
    chk("s2_done", 32'(done), 1);
    chk("s2_count", 32'(count), 1);
    @(negedge clk);
    chk("s2_idle_busy", 32'(busy), 0);
    chk("s2_idle_rdy", 32'(in_ready), 0);

    // Session 3: reset right after a beat is accepted discards the write.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h20;
    tick(1);
    start = 1'b0;
    send(1, T_I, 5'd1, 5'd1, 5'd0, 3'd0, 7'h00, 32'd5, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("s3_no_we", 32'(mem_we), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s3_busy", 32'(busy), 0);
    chk("s3_rdy", 32'(in_ready), 0);
    chk("s3_we", 32'(mem_we), 0);
    chk("s3_addr", 32'(mem_addr), 0);
    chk("s3_wdata", mem_wdata, 0);
    chk("s3_count", 32'(count), 0);
    chk("s3_done", 32'(done), 0);

    // Session 4: 4-word memory from base 2 fills after two writes.
    @(posedge clk); #1;
    start2 = 1'b1; base_addr2 = 2'd2;
    tick(1);
    start2 = 1'b0;
    q2.push_back({32'd2, 32'h403100B3}); send(2, T_R, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0, 1'b0);
    q2.push_back({32'd3, 32'hFFF00093}); send(2, T_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 1'b0);
    itype = T_J; rd = 5'd1; imm = 32'h800; in_valid2 = 1'b1;
    @(negedge clk);
    chk("s4_done", 32'(done2), 1);
    chk("s4_full", 32'(full2), 1);
    chk("s4_count", 32'(count2), 2);
    chk("s4_rdy_drain", 32'(in_ready2), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s4_rdy_idle", 32'(in_ready2), 0);
      chk("s4_busy_idle", 32'(busy2), 0);
    end
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    start2 = 1'b1; base_addr2 = 2'd0;
    tick(1);
    start2 = 1'b0;
    @(negedge clk);
    chk("s4_full_clr", 32'(full2), 0);
    chk("s4_busy_new", 32'(busy2), 1);
    @(posedge clk); #1;
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(3);

    chk("q1_empty", 32'(q1.size()), 0);
    chk("q2_empty", 32'(q2.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
